// File: rtl/io_channel_dispatcher.sv
// io_channel_dispatcher
// Routes core IO commands to one of CHANNELS port controllers by address,
// limits outstanding loads per channel, answers out-of-range loads with a
// fixed error value, and merges channel writebacks through a registered
// round-robin arbiter.
module io_channel_dispatcher #(
  parameter int DATABITWIDTH = 16,
  parameter int CHANNELS     = 4,
  parameter int IOBASEADDR   = 384,
  parameter int CHANSPANLOG2 = 3,
  parameter int MAXPENDING   = 2,
  parameter int ERRDATA      = 0
) (
  input  logic                               sys_clk,
  input  logic                               clk_en,
  input  logic                               sync_rst,
  input  logic                               CommandACK,
  output logic                               CommandREQ,
  input  logic [3:0]                         MinorOpcodeIn,
  input  logic [DATABITWIDTH-1:0]            CommandAddressIn,
  input  logic [DATABITWIDTH-1:0]            CommandDataIn,
  input  logic [3:0]                         CommandDestReg,
  output logic [CHANNELS-1:0]                ChanCommandACK,
  input  logic [CHANNELS-1:0]                ChanCommandREQ,
  output logic [3:0]                         ChanMinorOpcode,
  output logic [CHANSPANLOG2-1:0]            ChanAddrOffset,
  output logic [DATABITWIDTH-1:0]            ChanData,
  output logic [3:0]                         ChanDestReg,
  input  logic [CHANNELS-1:0]                ChanWritebackACK,
  output logic [CHANNELS-1:0]                ChanWritebackREQ,
  input  logic [CHANNELS*4-1:0]              ChanWritebackDestReg,
  input  logic [CHANNELS*DATABITWIDTH-1:0]   ChanWritebackData,
  output logic                               WritebackACK,
  input  logic                               WritebackREQ,
  output logic [3:0]                         WritebackDestReg,
  output logic [DATABITWIDTH-1:0]            WritebackDataOut,
  output logic [7:0]                         ErrorCount
);

  // The error slot is the extra requester just above the last channel.
  localparam int NREQ = CHANNELS + 1;
  localparam int RRW  = $clog2(NREQ);
  localparam int PW   = $clog2(MAXPENDING + 1);
  localparam int IDXW = DATABITWIDTH - CHANSPANLOG2;

  logic [DATABITWIDTH-1:0] offset;
  logic [IDXW-1:0]         chanIndex;
  logic                    isLoad;
  logic                    inRange;
  logic                    throttle;
  logic                    selReq;
  logic                    cmdAccept;
  logic                    oorAccept;
  logic                    errCapture;
  logic [CHANNELS-1:0]     chanHit;
  logic [CHANNELS-1:0]     loadInc;
  logic [PW-1:0]           pending [CHANNELS];
  logic                    errValid;
  logic [3:0]              errDest;
  logic [RRW-1:0]          rrPtr;
  logic [RRW-1:0]          grantIdx;
  logic                    grantFound;
  logic                    canGrant;
  logic                    grant;
  logic                    grantErr;
  logic [NREQ-1:0]         reqVec;
  logic [3:0]              grantDest;
  logic [DATABITWIDTH-1:0] grantData;
  int                      cand;

  assign offset    = CommandAddressIn - DATABITWIDTH'(IOBASEADDR);
  assign chanIndex = offset[DATABITWIDTH-1:CHANSPANLOG2];
  assign isLoad    = MinorOpcodeIn[3] & ~MinorOpcodeIn[2];
  assign inRange   = (CommandAddressIn >= DATABITWIDTH'(IOBASEADDR)) &&
                     (chanIndex < IDXW'(CHANNELS));

  assign ChanMinorOpcode = MinorOpcodeIn;
  assign ChanAddrOffset  = offset[CHANSPANLOG2-1:0];
  assign ChanData        = CommandDataIn;
  assign ChanDestReg     = CommandDestReg;

  // Decode the target channel and decide whether a load there must wait.
  always_comb begin
    chanHit  = '0;
    selReq   = 1'b0;
    throttle = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (inRange && chanIndex == IDXW'(k)) begin
        chanHit[k] = 1'b1;
        selReq     = ChanCommandREQ[k];
        throttle   = isLoad && (pending[k] == PW'(MAXPENDING));
      end
    end
  end

  // Command handshake: forward in-range commands, absorb out-of-range ones.
  always_comb begin
    CommandREQ     = 1'b0;
    ChanCommandACK = '0;
    if (clk_en) begin
      if (inRange) begin
        CommandREQ = selReq & ~throttle;
        if (CommandACK && !throttle) begin
          ChanCommandACK = chanHit;
        end
      end else if (isLoad) begin
        CommandREQ = ~errValid;
      end else begin
        CommandREQ = 1'b1;
      end
    end
  end

  assign cmdAccept  = CommandACK & CommandREQ;
  assign loadInc    = (cmdAccept && inRange && isLoad) ? chanHit : '0;
  assign oorAccept  = cmdAccept & ~inRange;
  assign errCapture = oorAccept & isLoad;

  assign reqVec   = {errValid, ChanWritebackACK};
  assign canGrant = clk_en && (!WritebackACK || WritebackREQ);
  assign grant    = canGrant & grantFound;
  assign grantErr = grant && (grantIdx == RRW'(CHANNELS));

  // Round-robin search starting at the requester after the last winner.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(rrPtr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grantFound && reqVec[RRW'(cand)]) begin
        grantFound = 1'b1;
        grantIdx   = RRW'(cand);
      end
    end
  end

  // Steer the winning requester's payload and grant strobe.
  always_comb begin
    ChanWritebackREQ = '0;
    grantDest        = errDest;
    grantData        = DATABITWIDTH'(ERRDATA);
    for (int k = 0; k < CHANNELS; k++) begin
      if (grantIdx == RRW'(k)) begin
        grantDest           = ChanWritebackDestReg[k*4 +: 4];
        grantData           = ChanWritebackData[k*DATABITWIDTH +: DATABITWIDTH];
        ChanWritebackREQ[k] = grant;
      end
    end
  end

  // Outstanding-load counters; unsolicited responses at zero leave it at zero.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      for (int k = 0; k < CHANNELS; k++) pending[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (loadInc[k] && !ChanWritebackREQ[k]) begin
          pending[k] <= pending[k] + PW'(1);
        end else if (!loadInc[k] && ChanWritebackREQ[k] && pending[k] != '0) begin
          pending[k] <= pending[k] - PW'(1);
        end
      end
    end
  end

  // Error slot: holds one out-of-range load until the arbiter returns it.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      errValid <= 1'b0;
      errDest  <= '0;
    end else if (errCapture) begin
      errValid <= 1'b1;
      errDest  <= CommandDestReg;
    end else if (grantErr) begin
      errValid <= 1'b0;
    end
  end

  // Saturating count of every accepted out-of-range command.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      ErrorCount <= '0;
    end else if (oorAccept && ErrorCount != 8'hFF) begin
      ErrorCount <= ErrorCount + 8'd1;
    end
  end

  // Advance the round-robin pointer past each winner.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      rrPtr <= '0;
    end else if (grant) begin
      rrPtr <= (grantIdx == RRW'(NREQ - 1)) ? '0 : grantIdx + RRW'(1);
    end
  end

  // Output buffer: load on grant, clear once drained, hold while stalled.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      WritebackACK     <= 1'b0;
      WritebackDestReg <= '0;
      WritebackDataOut <= '0;
    end else if (clk_en) begin
      if (grant) begin
        WritebackACK     <= 1'b1;
        WritebackDestReg <= grantDest;
        WritebackDataOut <= grantData;
      end else if (WritebackACK && WritebackREQ) begin
        WritebackACK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_channel_dispatcher.sv
// Randomized bench for io_channel_dispatcher against a transaction-level
// model of channel decode, pending counts, error slot and round-robin merge.
module tb_io_channel_dispatcher;

  localparam int DW   = 16;
  localparam int CH   = 4;
  localparam int BASE = 384;
  localparam int SPL  = 3;
  localparam int MAXP = 2;
  localparam int NREQ = CH + 1;
  localparam int NCYC = 4000;

  logic            sys_clk = 1'b0;
  logic            clk_en;
  logic            sync_rst;
  logic            CommandACK;
  logic            CommandREQ;
  logic [3:0]      MinorOpcodeIn;
  logic [DW-1:0]   CommandAddressIn;
  logic [DW-1:0]   CommandDataIn;
  logic [3:0]      CommandDestReg;
  logic [CH-1:0]   ChanCommandACK;
  logic [CH-1:0]   ChanCommandREQ;
  logic [3:0]      ChanMinorOpcode;
  logic [SPL-1:0]  ChanAddrOffset;
  logic [DW-1:0]   ChanData;
  logic [3:0]      ChanDestReg;
  logic [CH-1:0]   ChanWritebackACK;
  logic [CH-1:0]   ChanWritebackREQ;
  logic [CH*4-1:0] ChanWritebackDestReg;
  logic [CH*DW-1:0] ChanWritebackData;
  logic            WritebackACK;
  logic            WritebackREQ;
  logic [3:0]      WritebackDestReg;
  logic [DW-1:0]   WritebackDataOut;
  logic [7:0]      ErrorCount;

  int checks   = 0;
  int failures = 0;

  int mPend [CH];
  bit mErrValid;
  int mErrDest;
  int mRR;
  bit mBufValid;
  int mBufDest;
  int mBufData;
  int mErrCount;

  io_channel_dispatcher #(
    .DATABITWIDTH(DW), .CHANNELS(CH), .IOBASEADDR(BASE),
    .CHANSPANLOG2(SPL), .MAXPENDING(MAXP), .ERRDATA(0)
  ) dut (
    .sys_clk(sys_clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .CommandACK(CommandACK), .CommandREQ(CommandREQ),
    .MinorOpcodeIn(MinorOpcodeIn), .CommandAddressIn(CommandAddressIn),
    .CommandDataIn(CommandDataIn), .CommandDestReg(CommandDestReg),
    .ChanCommandACK(ChanCommandACK), .ChanCommandREQ(ChanCommandREQ),
    .ChanMinorOpcode(ChanMinorOpcode), .ChanAddrOffset(ChanAddrOffset),
    .ChanData(ChanData), .ChanDestReg(ChanDestReg),
    .ChanWritebackACK(ChanWritebackACK), .ChanWritebackREQ(ChanWritebackREQ),
    .ChanWritebackDestReg(ChanWritebackDestReg), .ChanWritebackData(ChanWritebackData),
    .WritebackACK(WritebackACK), .WritebackREQ(WritebackREQ),
    .WritebackDestReg(WritebackDestReg), .WritebackDataOut(WritebackDataOut),
    .ErrorCount(ErrorCount)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit doReset, input bit idle);
    int r;
    sync_rst = doReset;
    if (idle) begin
      clk_en = 1'b1; CommandACK = 1'b0; MinorOpcodeIn = '0;
      CommandAddressIn = '0; CommandDataIn = '0; CommandDestReg = '0;
      ChanCommandREQ = '0; ChanWritebackACK = '0; ChanWritebackDestReg = '0;
      ChanWritebackData = '0; WritebackREQ = 1'b0;
      return;
    end
    clk_en     = ($urandom_range(0, 9) != 0);
    CommandACK = ($urandom_range(0, 9) < 7);
    r = $urandom_range(0, 99);
    if (r < 70)      CommandAddressIn = 16'(BASE + $urandom_range(0, CH*8 - 1));
    else if (r < 85) CommandAddressIn = 16'(BASE + CH*8 + $urandom_range(0, 200));
    else             CommandAddressIn = 16'($urandom_range(0, BASE - 1));
    MinorOpcodeIn  = ($urandom_range(0, 1) == 1) ? 4'(8 + $urandom_range(0, 3))
                                                  : 4'($urandom_range(0, 15));
    CommandDataIn  = 16'($urandom);
    CommandDestReg = 4'($urandom);
    for (int k = 0; k < CH; k++) begin
      ChanCommandREQ[k]              = ($urandom_range(0, 9) < 8);
      ChanWritebackACK[k]            = ($urandom_range(0, 9) < 3);
      ChanWritebackDestReg[k*4 +: 4] = 4'($urandom);
      ChanWritebackData[k*DW +: DW]  = 16'($urandom);
    end
    WritebackREQ = ($urandom_range(0, 9) < 7);
  endtask

  task automatic resetModel();
    for (int k = 0; k < CH; k++) mPend[k] = 0;
    mErrValid = 0; mErrDest = 0; mRR = 0;
    mBufValid = 0; mBufDest = 0; mBufData = 0; mErrCount = 0;
  endtask

  // Compare this cycle's outputs against the model, then advance the model
  // to what the next rising edge should produce.
  task automatic modelCheckAndStep();
    int  addr, off, idx, winner, c;
    bit  isLoad, inR, thr, expReq, accepted, canG, grantB, rq;
    logic [CH-1:0] expAck, expWbReq;
    addr   = int'(CommandAddressIn);
    off    = addr - BASE;
    isLoad = MinorOpcodeIn[3] && !MinorOpcodeIn[2];
    inR    = (addr >= BASE) && ((off / 8) < CH);
    idx    = inR ? off / 8 : 0;
    thr    = inR && isLoad && (mPend[idx] == MAXP);
    if (!clk_en)    expReq = 0;
    else if (inR)   expReq = ChanCommandREQ[idx] && !thr;
    else if (isLoad) expReq = !mErrValid;
    else            expReq = 1;
    expAck = (clk_en && inR && CommandACK && !thr) ? CH'(1 << idx) : '0;
    accepted = CommandACK && expReq;

    winner = -1;
    for (int j = 0; j < NREQ; j++) begin
      c  = (mRR + j) % NREQ;
      rq = (c == CH) ? mErrValid : ChanWritebackACK[c];
      if (winner < 0 && rq) winner = c;
    end
    canG   = clk_en && (!mBufValid || WritebackREQ);
    grantB = canG && (winner >= 0);
    expWbReq = (grantB && winner < CH) ? CH'(1 << winner) : '0;

    checkOutput("CommandREQ", 32'(CommandREQ), 32'(expReq));
    checkOutput("ChanCommandACK", 32'(ChanCommandACK), 32'(expAck));
    checkOutput("ChanAddrOffset", 32'(ChanAddrOffset), 32'(off & 7));
    checkOutput("ChanWritebackREQ", 32'(ChanWritebackREQ), 32'(expWbReq));
    checkOutput("WritebackACK", 32'(WritebackACK), 32'(mBufValid));
    checkOutput("WritebackDestReg", 32'(WritebackDestReg), 32'(mBufDest));
    checkOutput("WritebackDataOut", 32'(WritebackDataOut), 32'(mBufData));
    checkOutput("ErrorCount", 32'(ErrorCount), 32'(mErrCount));

    if (sync_rst) begin
      resetModel();
    end else if (clk_en) begin
      for (int k = 0; k < CH; k++) begin
        bit inc, dec;
        inc = accepted && inR && isLoad && (idx == k);
        dec = grantB && (winner == k);
        if (inc && !dec) mPend[k] = mPend[k] + 1;
        else if (dec && !inc && mPend[k] > 0) mPend[k] = mPend[k] - 1;
      end
      if (grantB) begin
        mBufValid = 1;
        if (winner == CH) begin
          mBufDest = mErrDest; mBufData = 0; mErrValid = 0;
        end else begin
          mBufDest = int'(ChanWritebackDestReg[winner*4 +: 4]);
          mBufData = int'(ChanWritebackData[winner*DW +: DW]);
        end
        mRR = (winner + 1) % NREQ;
      end else if (mBufValid && WritebackREQ) begin
        mBufValid = 0;
      end
      if (accepted && !inR) begin
        if (isLoad) begin
          mErrValid = 1; mErrDest = int'(CommandDestReg);
        end
        if (mErrCount < 255) mErrCount = mErrCount + 1;
      end
    end
  endtask

  // Reset, one idle check, then a long randomized run with a mid-run reset.
  initial begin
    resetModel();
    applyStimulus(1'b1, 1'b1);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sys_clk);
      if (cyc < 3)                           applyStimulus(1'b1, 1'b1);
      else if (cyc == 3)                     applyStimulus(1'b0, 1'b1);
      else if (cyc == 2000 || cyc == 2001)   applyStimulus(1'b1, 1'b0);
      else                                   applyStimulus(($urandom_range(0, 999) == 0), 1'b0);
      #1;
      modelCheckAndStep();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_channel_dispatcher.md
# io_channel_dispatcher

Parametrised IO command dispatcher and writeback arbiter that sits between the core's IO command/writeback handshakes and CHANNELS uniform IO port controllers. It decodes the IO address into a channel index, forwards commands with per-channel outstanding-load throttling, and returns out-of-range loads with a fixed error value. It merges channel writebacks through a registered round-robin arbiter. It generalises the fixed-count IO manager to arbitrary channel count, span and pending depth.

## Interface
- DATABITWIDTH, 16, data/address width
- CHANNELS, 4, number of IO channels (1..16)
- IOBASEADDR, 384, first byte address of channel 0
- CHANSPANLOG2, 3, log2 bytes per channel; channel k owns [IOBASEADDR + k·2^CHANSPANLOG2, +2^CHANSPANLOG2−1]
- MAXPENDING, 2, max outstanding loads per channel (≥1)
- ERRDATA, 0, data returned for out-of-range loads

Ports:
- sys_clk  in  1  clock
- clk_en  in  1  global clock enable
- sync_rst  in  1  synchronous active-high reset
- CommandACK  in  1  upstream command valid
- CommandREQ  out  1  command accepted when CommandACK && CommandREQ
- MinorOpcodeIn  in  4  bit3&~bit2 = load, bit2 = store
- CommandAddressIn  in  DATABITWIDTH  absolute IO address
- CommandDataIn  in  DATABITWIDTH  store data
- CommandDestReg  in  4  load destination register
- ChanCommandACK  out  CHANNELS  one-hot command valid
- ChanCommandREQ  in  CHANNELS  per-channel ready
- ChanMinorOpcode / ChanAddrOffset / ChanData / ChanDestReg  out  4 / CHANSPANLOG2 / DATABITWIDTH / 4  shared command bus
- ChanWritebackACK  in  CHANNELS  per-channel writeback valid
- ChanWritebackREQ  out  CHANNELS  per-channel writeback grant
- ChanWritebackDestReg  in  CHANNELS×4  packed
- ChanWritebackData  in  CHANNELS×DATABITWIDTH  packed
- WritebackACK  out  1  merged writeback valid
- WritebackREQ  in  1  downstream ready
- WritebackDestReg  out  4
- WritebackDataOut  out  DATABITWIDTH
- ErrorCount  out  8  saturating count of out-of-range commands

## Operation
- Offset = CommandAddressIn − IOBASEADDR (DATABITWIDTH wrap). Index = Offset >> CHANSPANLOG2; in range iff CommandAddressIn ≥ IOBASEADDR and Index < CHANNELS. ChanAddrOffset = Offset[CHANSPANLOG2−1:0].
- In range: ChanCommandACK[Index] = CommandACK && ~throttle; CommandREQ = ChanCommandREQ[Index] && ~throttle. throttle = load && Pending[Index] == MAXPENDING. Command path is combinational.
- Out of range, load: accepted only when the error slot is empty; slot captures {CommandDestReg, ERRDATA}. Out-of-range store or other opcode: always accepted (CommandREQ=1) and dropped. Each out-of-range acceptance increments ErrorCount, saturating at 255.
- Pending[k] (width clog2(MAXPENDING+1)): +1 on accepted load to k, −1 on granted writeback from k. Both in one cycle: unchanged. A decrement at 0 holds 0, because unsolicited responses are legal.
- Arbiter requesters: channels 0..CHANNELS−1 plus the error slot at index CHANNELS. Round-robin from pointer RR; grant only when output buffer is empty or draining this cycle (WritebackACK && WritebackREQ). On grant: ChanWritebackREQ[w]=1 (or the error slot clears), buffer loads, RR ← w+1 mod (CHANNELS+1).
- clk_en low: all state holds; CommandREQ, ChanCommandACK and ChanWritebackREQ are forced 0; WritebackACK holds its value but no transfer completes.

## Timing
- Reset values: WritebackACK 0, WritebackDestReg 0, WritebackDataOut 0, ErrorCount 0, all Pending 0, RR 0, error slot empty. Combinational outputs follow inputs.
- Command forward latency: 0 cycles. Writeback latency: 1 cycle from grant to WritebackACK. Full throughput is 1 writeback per cycle under continuous WritebackREQ.
- Output buffer holds data stable while WritebackACK && ~WritebackREQ.
- A sync_rst mid-transfer drops the buffered writeback and any error slot contents.

## Test plan
- Reset then idle -> all outputs 0, CommandREQ follows decoded channel REQ.
- Load to addr 384+8 (CHANSPANLOG2=3) -> ChanCommandACK=0b0010, ChanAddrOffset=0. A third load with MAXPENDING=2 and no writeback -> CommandREQ=0 until channel 1 writeback is granted.
- All 4 channels assert ChanWritebackACK with WritebackREQ=1 held -> grants in order 0,1,2,3 on consecutive cycles, WritebackACK continuous.
- Load to addr 384+40 -> writeback {DestReg, 0x0000} next arbitration, ErrorCount=1. A second bad load while the slot is full -> CommandREQ=0.
- WritebackREQ low for 3 cycles with pending writeback -> data held stable, no new ChanWritebackREQ.
- Accepted load and granted writeback on the same channel in one cycle -> Pending unchanged. An unsolicited writeback at Pending=0 -> stays 0.
